// File: rtl/sprite_line_fetch_if.sv
// Signal bundle for sprite_line_fetch: attribute writes, the line/pixel timing,
// the pattern-memory read port and the per-pixel sprite stream.
interface sprite_line_fetch_if;
  logic        attr_we;
  logic [2:0]  attr_sel;
  logic [31:0] attr_wdata;
  logic        line_start;
  logic [9:0]  next_y;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [8:0]  sprite_index;
  logic        sprite_enable;
  logic        fetch_done;
  logic        overrun;

  modport master (
    output attr_we, attr_sel, attr_wdata, line_start, next_y,
           mem_ack, mem_rdata, pixel_valid, pixel_x,
    input  mem_req, mem_addr, sprite_index, sprite_enable, fetch_done, overrun
  );

  modport slave (
    input  attr_we, attr_sel, attr_wdata, line_start, next_y,
           mem_ack, mem_rdata, pixel_valid, pixel_x,
    output mem_req, mem_addr, sprite_index, sprite_enable, fetch_done, overrun
  );
endinterface

// File: rtl/sprite_line_fetch.sv
// Sprite line fetcher: during hblank, reads 16x16 4bpp pattern rows for sprites on
// the next line, then emits the highest-priority opaque sprite pixel per column.
module sprite_line_fetch #(
  parameter int          SPRITES      = 4,
  parameter logic [15:0] PATTERN_BASE = 16'h8000
) (
  input logic                clk,
  input logic                rst_n,
  sprite_line_fetch_if.slave bus
);
  localparam int         MAX_SPRITES = 8;
  localparam logic [2:0] LAST        = 3'(SPRITES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct packed {
    logic       en;
    logic [4:0] pal;
    logic [9:0] y;
    logic [9:0] x;
    logic [5:0] tile;
  } attr_t;

  attr_t       attr [MAX_SPRITES];
  logic [2:0]  state;
  logic [2:0]  idx;
  logic [1:0]  w;
  logic [9:0]  cur_y;
  logic [5:0]  tile_q;
  logic [3:0]  row_q;
  logic        drain;
  logic        overrun_q;
  logic        pend_valid [MAX_SPRITES];
  logic        act_valid  [MAX_SPRITES];
  logic [9:0]  pend_x     [MAX_SPRITES];
  logic [9:0]  act_x      [MAX_SPRITES];
  logic [4:0]  pend_pal   [MAX_SPRITES];
  logic [4:0]  act_pal    [MAX_SPRITES];
  logic [63:0] pend_row   [MAX_SPRITES];
  logic [63:0] act_row    [MAX_SPRITES];
  logic [8:0]  index_q;
  logic        enable_q;
  logic        mem_req;

  attr_t      scan_attr;
  logic [9:0] scan_row;
  logic       scan_hit;

  assign scan_attr = attr[idx];
  assign scan_row  = cur_y - scan_attr.y;
  assign scan_hit  = scan_attr.en && (scan_row[9:4] == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_SPRITES; k++) attr[k] <= '0;
    end else if (bus.attr_we && (int'(bus.attr_sel) < SPRITES)) begin
      attr[bus.attr_sel] <= attr_t'(bus.attr_wdata);
    end
  end

  // A line_start during FETCH leaves the read in flight; drain keeps the request
  // up until its ack and stalls SCAN so the restarted fetch never sees that data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      w         <= '0;
      cur_y     <= '0;
      tile_q    <= '0;
      row_q     <= '0;
      drain     <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < MAX_SPRITES; k++) begin
        pend_valid[k] <= 1'b0;
        act_valid[k]  <= 1'b0;
      end
    end else if (bus.line_start) begin
      overrun_q <= (state != S_IDLE) && (state != S_DONE);
      drain     <= (drain || (state == S_FETCH)) && !bus.mem_ack;
      cur_y     <= bus.next_y;
      idx       <= '0;
      state     <= S_SCAN;
      for (int k = 0; k < MAX_SPRITES; k++) begin
        act_valid[k]  <= pend_valid[k];
        pend_valid[k] <= 1'b0;
      end
    end else begin
      overrun_q <= 1'b0;
      case (state)
        S_SCAN: begin
          if (drain) begin
            if (bus.mem_ack) drain <= 1'b0;
          end else if (scan_hit) begin
            tile_q <= scan_attr.tile;
            row_q  <= scan_row[3:0];
            w      <= '0;
            state  <= S_FETCH;
          end else begin
            state <= S_NEXT;
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            if (w == 2'd3) begin
              pend_valid[idx] <= 1'b1;
              state           <= S_NEXT;
            end else begin
              w <= w + 2'd1;
            end
          end
        end
        S_NEXT: begin
          if (idx == LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= S_SCAN;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: position, palette and pattern storage carry no reset; the valid bits above gate every use.
  always_ff @(posedge clk) begin
    if (bus.line_start) begin
      for (int k = 0; k < MAX_SPRITES; k++) begin
        act_x[k]   <= pend_x[k];
        act_pal[k] <= pend_pal[k];
        act_row[k] <= pend_row[k];
      end
    end else begin
      if ((state == S_SCAN) && !drain && scan_hit) begin
        pend_x[idx]   <= scan_attr.x;
        pend_pal[idx] <= scan_attr.pal;
      end
      if ((state == S_FETCH) && bus.mem_ack) pend_row[idx][{~w, 4'b0000} +: 16] <= bus.mem_rdata;
    end
  end

  logic       win;
  logic [8:0] win_index;
  logic [9:0] col;
  logic [3:0] colour;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    win       = 1'b0;
    win_index = '0;
    col       = '0;
    colour    = '0;
    // Walk from lowest priority upward so sprite 0 overwrites any other winner.
    for (int k = SPRITES - 1; k >= 0; k--) begin
      col    = bus.pixel_x - act_x[k];
      colour = act_row[k][{~col[3:0], 2'b00} +: 4];
      if (act_valid[k] && (col[9:4] == 6'd0) && (colour != 4'd0)) begin
        win       = 1'b1;
        win_index = {act_pal[k], colour};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q  <= '0;
      enable_q <= 1'b0;
    end else if (bus.pixel_valid && win) begin
      index_q  <= win_index;
      enable_q <= 1'b1;
    end else begin
      index_q  <= '0;
      enable_q <= 1'b0;
    end
  end

  assign mem_req           = (state == S_FETCH) || drain;
  assign bus.mem_req       = mem_req;
  assign bus.mem_addr      = mem_req ? PATTERN_BASE + {4'b0000, tile_q, row_q, w} : 16'h0000;
  assign bus.fetch_done    = (state == S_DONE);
  assign bus.overrun       = overrun_q;
  assign bus.sprite_index  = index_q;
  assign bus.sprite_enable = enable_q;
endmodule
